// File: rtl/cmd_exec_unit.sv
// cmd_exec_unit: command executor with a single-cycle ALU and a 64-step radix-2 divider.
// Optional macro CMD_EXEC_OOO_EN lets ALU commands issue and complete while a divide is in flight.
module cmd_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [2:0]  cmd,
  input  logic [63:0] opd1,
  input  logic [63:0] opd2,
  output logic        rdy,
  output logic        done,
  output logic [2:0]  done_cmd,
  output logic [63:0] result,
  output logic        err,
  output logic [1:0]  outstanding,
  output logic        halted
);

  localparam logic [2:0] OP_RST  = 3'd0;
  localparam logic [2:0] OP_INIT = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MULT = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_HLT  = 3'd7;

  typedef enum logic [1:0] {
    U_INIT = 2'd0,
    U_RUN  = 2'd1,
    U_HALT = 2'd2
  } unit_state_e;

  typedef enum logic {
    DV_IDLE = 1'b0,
    DV_BUSY = 1'b1
  } div_state_e;

  unit_state_e unit_q, unit_d;
  div_state_e  div_q, div_d;

  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [63:0] div_rem_q, div_rem_d;
  logic [63:0] div_quo_q, div_quo_d;
  logic [63:0] div_dsr_q, div_dsr_d;
  logic [2:0]  div_op_q, div_op_d;
  logic        div_dz_q, div_dz_d;

  logic        done_q, done_d;
  logic [2:0]  done_cmd_q, done_cmd_d;
  logic [63:0] result_q, result_d;
  logic        err_q, err_d;
  logic [1:0]  outstanding_q, outstanding_d;

  logic        is_div_cmd;
  logic        accept;
  logic        div_last;
  logic [64:0] rem_sh;
  logic [64:0] rem_diff;
  logic        rem_ge;
  logic [63:0] rem_nx;
  logic [63:0] quo_nx;
  logic [63:0] alu_res;

  assign is_div_cmd = (cmd == OP_DIV) || (cmd == OP_REM);
  assign div_last   = (div_q == DV_BUSY) && (div_cnt_q == 6'd63);
  assign accept     = vld && rdy;

  // Command acceptance: depends only on state and the presented opcode.
  always_comb begin
    rdy = 1'b0;
    if (unit_q == U_RUN) begin
      if (cmd == OP_HLT) begin
        rdy = (outstanding_q == 2'd0);
      end else if (div_q == DV_IDLE) begin
        rdy = 1'b1;
      end else begin
`ifdef CMD_EXEC_OOO_EN
        // Block the slot that would complete on the same edge as the divider.
        rdy = !is_div_cmd && !(div_cnt_q == 6'd63);
`else
        rdy = 1'b0;
`endif
      end
    end else begin
      rdy = 1'b0;
    end
  end

  // One restoring-division step. The remainder never needs bit 64 once the
  // subtraction is known to succeed, so the borrow alone decides the quotient bit.
  always_comb begin
    rem_sh   = {div_rem_q, div_quo_q[63]};
    rem_diff = rem_sh - {1'b0, div_dsr_q};
    rem_ge   = !rem_diff[64];
    if (rem_ge) begin
      rem_nx = rem_diff[63:0];
    end else begin
      rem_nx = rem_sh[63:0];
    end
    quo_nx = {div_quo_q[62:0], rem_ge};
  end

  // Single-cycle ALU result; HLT and RST both produce zero.
  always_comb begin
    alu_res = 64'd0;
    case (cmd)
      OP_RST:  alu_res = 64'd0;
      OP_INIT: alu_res = opd1;
      OP_ADD:  alu_res = opd1 + opd2;
      OP_SUB:  alu_res = opd1 - opd2;
      OP_MULT: alu_res = opd1 * opd2;
      default: alu_res = 64'd0;
    endcase
  end

  // Next-state for the unit FSM, divider FSM and completion port.
  always_comb begin
    unit_d     = unit_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_dsr_d  = div_dsr_q;
    div_op_d   = div_op_q;
    div_dz_d   = div_dz_q;
    done_d     = 1'b0;
    done_cmd_d = 3'd0;
    result_d   = 64'd0;
    err_d      = 1'b0;

    case (unit_q)
      U_INIT: unit_d = U_RUN;
      U_RUN: begin
        if (accept && (cmd == OP_HLT)) begin
          unit_d = U_HALT;
        end else begin
          unit_d = U_RUN;
        end
      end
      U_HALT:  unit_d = U_HALT;
      default: unit_d = U_INIT;
    endcase

    case (div_q)
      DV_IDLE: begin
        if (accept && is_div_cmd) begin
          div_d     = DV_BUSY;
          div_cnt_d = 6'd0;
          div_rem_d = 64'd0;
          div_quo_d = opd1;
          div_dsr_d = opd2;
          div_op_d  = cmd;
          div_dz_d  = (opd2 == 64'd0);
        end else begin
          div_d = DV_IDLE;
        end
      end
      DV_BUSY: begin
        div_rem_d = rem_nx;
        div_quo_d = quo_nx;
        div_cnt_d = div_cnt_q + 6'd1;
        if (div_last) begin
          div_d = DV_IDLE;
        end else begin
          div_d = DV_BUSY;
        end
      end
      default: div_d = DV_IDLE;
    endcase

    // Divider completion and ALU acceptance never coincide: rdy is low for that slot.
    if (div_last) begin
      done_d     = 1'b1;
      done_cmd_d = div_op_q;
      err_d      = div_dz_q;
      if (div_op_q == OP_DIV) begin
        result_d = quo_nx;
      end else begin
        result_d = rem_nx;
      end
    end else if (accept && !is_div_cmd) begin
      done_d     = 1'b1;
      done_cmd_d = cmd;
      result_d   = alu_res;
    end else begin
      done_d = 1'b0;
    end
  end

  // A command stays outstanding through its done cycle.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, done_q})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers with synchronous reset; reset also aborts any divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_q        <= U_INIT;
      div_q         <= DV_IDLE;
      div_cnt_q     <= 6'd0;
      div_rem_q     <= 64'd0;
      div_quo_q     <= 64'd0;
      div_dsr_q     <= 64'd0;
      div_op_q      <= 3'd0;
      div_dz_q      <= 1'b0;
      done_q        <= 1'b0;
      done_cmd_q    <= 3'd0;
      result_q      <= 64'd0;
      err_q         <= 1'b0;
      outstanding_q <= 2'd0;
    end else begin
      unit_q        <= unit_d;
      div_q         <= div_d;
      div_cnt_q     <= div_cnt_d;
      div_rem_q     <= div_rem_d;
      div_quo_q     <= div_quo_d;
      div_dsr_q     <= div_dsr_d;
      div_op_q      <= div_op_d;
      div_dz_q      <= div_dz_d;
      done_q        <= done_d;
      done_cmd_q    <= done_cmd_d;
      result_q      <= result_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign done        = done_q;
  assign done_cmd    = done_cmd_q;
  assign result      = result_q;
  assign err         = err_q;
  assign outstanding = outstanding_q;
  assign halted      = (unit_q == U_HALT);

endmodule

// File: tb/tb_cmd_exec_unit.sv
// Directed + randomized bench for cmd_exec_unit, checked against an arithmetic reference model.
module tb_cmd_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [2:0]  cmd;
  logic [63:0] opd1;
  logic [63:0] opd2;
  logic        rdy;
  logic        done;
  logic [2:0]  done_cmd;
  logic [63:0] result;
  logic        err;
  logic [1:0]  outstanding;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  cmd_exec_unit dut (
    .clk(clk), .rst(rst), .vld(vld), .cmd(cmd), .opd1(opd1), .opd2(opd2),
    .rdy(rdy), .done(done), .done_cmd(done_cmd), .result(result), .err(err),
    .outstanding(outstanding), .halted(halted)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what each opcode returns and how many edges until done is seen.
  function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic e, output int lat);
    e = 1'b0;
    lat = 1;
    case (op)
      3'd0: r = 64'd0;
      3'd1: r = a;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a * b;
      3'd5: begin
        lat = 65;
        if (b == 64'd0) begin r = ALL_ONES; e = 1'b1; end
        else r = a / b;
      end
      3'd6: begin
        lat = 65;
        if (b == 64'd0) begin r = a; e = 1'b1; end
        else r = a % b;
      end
      default: r = 64'd0;
    endcase
  endfunction

  // Present a command, wait (bounded) for rdy, let the next edge accept it.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int w;
    w = 0;
    cmd = op; opd1 = a; opd2 = b; vld = 1'b1;
    #1;
    while (!rdy && w < 200) begin
      tick();
      w++;
    end
    check("rdy_wait", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    model(op, a, b, exp_r, exp_e, exp_lat);
    issue(op, a, b);
    wait_done(lat);
    check({tag, "_cmd"}, 64'(done_cmd), 64'(op));
    check({tag, "_res"}, result, exp_r);
    check({tag, "_err"}, 64'(err), 64'(exp_e));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_outst"}, 64'(outstanding), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c;
    int          rdy_hi;
    int          pulses;
    logic [2:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;
    int          mode;

    rst = 1'b1; vld = 1'b0; cmd = 3'd2; opd1 = 64'd0; opd2 = 64'd0;
    repeat (3) tick();
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dcmd", 64'(done_cmd), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_outst", 64'(outstanding), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_rdy", 64'(rdy), 64'd1);

    run_and_check("add53", 3'd2, 64'd5, 64'd3);
    run_and_check("div100_7", 3'd5, 64'd100, 64'd7);
    run_and_check("rem100_7", 3'd6, 64'd100, 64'd7);
    run_and_check("div9_0", 3'd5, 64'd9, 64'd0);
    run_and_check("rem9_0", 3'd6, 64'd9, 64'd0);
    run_and_check("sub_wrap", 3'd3, 64'd0, 64'd1);
    run_and_check("mult_big", 3'd4, ALL_ONES, 64'd3);
    run_and_check("init", 3'd1, 64'h1234_5678_9ABC_DEF0, 64'd7);
    run_and_check("rstop", 3'd0, 64'd77, 64'd88);

    // DIV 64,8 followed by SUB 1,2
    issue(3'd5, 64'd64, 64'd8);
    cmd = 3'd3; opd1 = 64'd1; opd2 = 64'd2; vld = 1'b1;
    #1;
`ifdef CMD_EXEC_OOO_EN
    check("ooo_rdy", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    check("ooo_sub_done", 64'(done), 64'd1);
    check("ooo_sub_cmd", 64'(done_cmd), 64'd3);
    check("ooo_sub_res", result, ALL_ONES);
    check("ooo_outst2", 64'(outstanding), 64'd2);
    tick();
    check("ooo_sub_pulse", 64'(done), 64'd0);
    c = 3;
    while (!done && c < 200) begin
      tick();
      c++;
    end
    check("ooo_div_lat", 64'(c), 64'd65);
    check("ooo_div_cmd", 64'(done_cmd), 64'd5);
    check("ooo_div_res", result, 64'd8);
    tick();
    check("ooo_outst0", 64'(outstanding), 64'd0);
`else
    c = 1;
    rdy_hi = 0;
    while (!done && c < 200) begin
      if (rdy) rdy_hi++;
      tick();
      c++;
    end
    check("io_sub_blocked", 64'(rdy_hi), 64'd0);
    check("io_div_lat", 64'(c), 64'd65);
    check("io_div_cmd", 64'(done_cmd), 64'd5);
    check("io_div_res", result, 64'd8);
    check("io_rdy_at_done", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    check("io_sub_done", 64'(done), 64'd1);
    check("io_sub_cmd", 64'(done_cmd), 64'd3);
    check("io_sub_res", result, ALL_ONES);
    check("io_outst1", 64'(outstanding), 64'd1);
    tick();
    check("io_outst0", 64'(outstanding), 64'd0);
`endif

    // Reset in the middle of a divide
    issue(3'd5, 64'd12345, 64'd6);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_outst", 64'(outstanding), 64'd0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) pulses++;
    end
    check("mid_rst_no_done", 64'(pulses), 64'd0);
    run_and_check("init42", 3'd1, 64'd42, 64'd9);

    // Randomized commands against the model
    for (int i = 0; i < 24; i++) begin
      rop  = 3'($urandom_range(0, 6));
      ra   = {$urandom, $urandom};
      mode = int'($urandom_range(0, 3));
      if (mode == 0) rb = 64'd0;
      else if (mode == 1) rb = 64'($urandom_range(1, 255));
      else rb = {$urandom, $urandom};
      run_and_check($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // HLT presented during a DIV
    issue(3'd5, 64'd1000, 64'd3);
    cmd = 3'd7; opd1 = 64'd0; opd2 = 64'd0; vld = 1'b1;
    #1;
    c = 1;
    rdy_hi = 0;
    while (!done && c < 200) begin
      if (rdy) rdy_hi++;
      tick();
      c++;
    end
    check("hlt_blocked", 64'(rdy_hi), 64'd0);
    check("hlt_div_lat", 64'(c), 64'd65);
    check("hlt_div_res", result, 64'd333);
    check("hlt_rdy_done_cyc", 64'(rdy), 64'd0);
    tick();
    check("hlt_rdy_idle", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    check("hlt_done", 64'(done), 64'd1);
    check("hlt_cmd", 64'(done_cmd), 64'd7);
    check("hlt_res", result, 64'd0);
    check("hlt_halted", 64'(halted), 64'd1);
    rdy_hi = 0;
    vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd = 3'(i);
      #1;
      if (rdy) rdy_hi++;
      tick();
    end
    vld = 1'b0;
    check("halted_rdy_low", 64'(rdy_hi), 64'd0);
    check("halted_hold", 64'(halted), 64'd1);
    check("halted_no_done", 64'(done), 64'd0);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cmd = 3'd2;
    tick();
    check("final_halted", 64'(halted), 64'd0);
    check("final_rdy", 64'(rdy), 64'd1);
    run_and_check("final_add", 3'd2, ALL_ONES, 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_exec_unit.md
CMD_EXEC_UNIT -- requirements
Module: cmd_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port vld, input, 1, command valid.
REQ-004 SHALL have port cmd, input, 3, opcode: RST=0, INIT=1, ADD=2, SUB=3, MULT=4, DIV=5, REM=6, HLT=7.
REQ-005 SHALL have ports opd1 and opd2, input, 64 each, unsigned operands.
REQ-006 SHALL have port rdy, output, 1, command accept.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port done_cmd, output, 3, opcode of the completing command.
REQ-009 SHALL have port result, output, 64, result of the completing command.
REQ-010 SHALL have port err, output, 1, divide-by-zero flag, valid with done.
REQ-011 SHALL have port outstanding, output, 2, count of accepted but uncompleted commands.
REQ-012 SHALL have port halted, output, 1, HLT executed.

Function
REQ-013 SHALL accept a command at a rising clk edge where vld=1 and rdy=1, and at no other time.
REQ-014 SHALL compute results per opcode: RST -> 0; INIT -> opd1; ADD -> opd1+opd2 mod 2^64; SUB -> opd1-opd2 mod 2^64; MULT -> low 64 bits of opd1*opd2.
REQ-015 SHALL complete each ALU opcode (RST, INIT, ADD, SUB, MULT) by pulsing done in the cycle immediately after the acceptance edge, with done_cmd, result and err=0.
REQ-016 SHALL execute DIV and REM in a radix-2 iterative divider, with done pulsing exactly 65 cycles after the acceptance edge.
REQ-017 SHALL return quotient for DIV and remainder for REM.
REQ-018 SHALL, on opd2=0, return all-ones for DIV, opd1 for REM, and err=1, still after 65 cycles.
REQ-019 SHALL drive rdy=0 for HLT while outstanding!=0; HLT accepted with outstanding=0 completes like an ALU op with result 0.
REQ-020 SHALL, in the HLT done cycle, set halted=1 and hold rdy=0 until rst.
REQ-021 SHALL update outstanding +1 on acceptance and -1 on done; when both occur in the same cycle, outstanding is unchanged.
REQ-022 SHALL never assert done for two commands in one cycle.
REQ-023 SHALL keep rdy combinational from state, cmd and vld only.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, force rdy=0, done=0, done_cmd=0, result=0, err=0, outstanding=0 and halted=0.
REQ-025 SHALL abort any in-flight divide on rst with no done, and set rdy=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL use macro CMD_EXEC_OOO_EN to select completion ordering.
REQ-027 SHALL, without CMD_EXEC_OOO_EN, operate in order: rdy=0 from DIV/REM acceptance until its done cycle, rdy=1 in that cycle, and outstanding never exceeds 1 after a DIV/REM.
REQ-028 SHALL, with CMD_EXEC_OOO_EN and the divider busy, keep rdy=1 for ALU opcodes and rdy=0 for DIV, REM and HLT.
REQ-029 SHALL, with CMD_EXEC_OOO_EN, allow ALU ops to complete before an older DIV/REM, with outstanding up to 2.
REQ-030 SHALL, with CMD_EXEC_OOO_EN, drive rdy=0 in the cycle before divider done, so that no ALU completion collides with it.

Verification
REQ-031 SHALL cover: reset, then ADD 5,3 accepted at edge N -> done at N+1, done_cmd=2, result=8, outstanding back to 0.
REQ-032 SHALL cover: DIV 100,7 -> done 65 cycles after acceptance, result=14; REM 100,7 -> result=2, err=0.
REQ-033 SHALL cover: DIV 9,0 -> result=0xFFFF_FFFF_FFFF_FFFF, err=1; REM 9,0 -> result=9, err=1.
REQ-034 SHALL cover: HLT presented during a DIV -> rdy=0 until the DIV done; HLT then done, halted=1, rdy=0 until rst.
REQ-035 SHALL cover, with CMD_EXEC_OOO_EN: DIV 64,8 then SUB 1,2 -> SUB done first with result=0xFFFF_FFFF_FFFF_FFFF, outstanding=2 peak, DIV result=8; without the macro, SUB waits on rdy=0.
REQ-036 SHALL cover: rst asserted mid-DIV -> no done pulse, outstanding=0, and a subsequent INIT 42 completes with result=42.
